// File: rtl/mem_pkg.sv
// Shared constants and address-decode helpers for the four-bank memory controller.
package mem_pkg;

  localparam int BANK_BUSY_DEFAULT = 4;
  localparam int RD_LAT_DEFAULT    = 2;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int BANK_W    = 2;
  localparam int ROW_W     = 13;
  localparam int NUM_BANKS = 1 << BANK_W;
  localparam int ROW_DEPTH = 1 << ROW_W;

  localparam int BANK_LSB = 1;
  localparam int BANK_MSB = BANK_LSB + BANK_W - 1;
  localparam int ROW_LSB  = BANK_MSB + 1;
  localparam int ROW_MSB  = ROW_LSB + ROW_W - 1;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[BANK_MSB:BANK_LSB];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ROW_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One memory bank: 8K x 16 storage, occupancy down-counter and fixed-latency read pipeline.
module mem_bank
  import mem_pkg::*;
#(
  parameter int BANK_BUSY = BANK_BUSY_DEFAULT,
  parameter int RD_LAT    = RD_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_rd,
  input  logic              acc_wr,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CNT_W = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_BUSY - 1);

  logic [DATA_W-1:0] mem [ROW_DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] head_data;

  // Storage is not reset; the read register samples every cycle and is qualified by vld_q.
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem[row] <= data_in;
    end
    ram_q <= mem[row];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (acc_rd || acc_wr) begin
      cnt_q <= CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign busy = (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= acc_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data is zeroed when not valid so the top level can simply OR the bank returns.
  assign head_data = vld_q[0] ? ram_q : '0;
  assign rd_valid  = vld_q[RD_LAT-1];

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rd_data = head_data;
    end else begin : g_latn
      logic [DATA_W-1:0] dat_q [RD_LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < RD_LAT - 1; i++) begin
            dat_q[i] <= '0;
          end
        end else begin
          dat_q[0] <= head_data;
          for (int i = 1; i < RD_LAT - 1; i++) begin
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign rd_data = dat_q[RD_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/mem_bank_ctrl.sv
// Four-bank memory controller: bank decode, accept/stall/err generation, read-return merge.
// Optional MEM_ALIGN_CHECK_EN rejects requests with addr[0] set as illegal.
module mem_bank_ctrl
  import mem_pkg::*;
#(
  parameter int BANK_BUSY = BANK_BUSY_DEFAULT,
  parameter int RD_LAT    = RD_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  logic [BANK_W-1:0]    bank;
  logic [ROW_W-1:0]     row;
  logic [NUM_BANKS-1:0] bank_sel;
  logic                 illegal;
  logic                 accept;
  logic [NUM_BANKS-1:0] acc_rd;
  logic [NUM_BANKS-1:0] acc_wr;
  logic [NUM_BANKS-1:0] bank_vld;
  logic [DATA_W-1:0]    bank_data [NUM_BANKS];

  assign bank = bank_of(addr);
  assign row  = row_of(addr);

`ifdef MEM_ALIGN_CHECK_EN
  assign illegal = (rd & wr) | ((rd | wr) & addr[0]);
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = addr[0];
  assign illegal = rd & wr;
`endif

  // Requests during reset are ignored outright, so every control output is gated by rst.
  assign err    = ~rst & illegal;
  assign stall  = ~rst & (rd | wr) & busy[bank] & ~illegal;
  assign accept = ~rst & (rd ^ wr) & ~busy[bank] & ~illegal;

  always_comb begin
    bank_sel       = '0;
    bank_sel[bank] = 1'b1;
  end

  assign acc_rd = {NUM_BANKS{accept & rd}} & bank_sel;
  assign acc_wr = {NUM_BANKS{accept & wr}} & bank_sel;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      mem_bank #(
        .BANK_BUSY (BANK_BUSY),
        .RD_LAT    (RD_LAT)
      ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .acc_rd   (acc_rd[b]),
        .acc_wr   (acc_wr[b]),
        .row      (row),
        .data_in  (data_in),
        .busy     (busy[b]),
        .rd_valid (bank_vld[b]),
        .rd_data  (bank_data[b])
      );
    end
  endgenerate

  always_comb begin
    data_out = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      data_out = data_out | bank_data[b];
    end
  end

  assign rd_valid = |bank_vld;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed self-checking bench for mem_bank_ctrl; honours MEM_ALIGN_CHECK_EN like the RTL.
module tb_mem_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  mem_bank_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the rising edge, then wait to the falling edge to sample.
  task automatic applyStimulus(input logic r_st, input logic r, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    rst     = r_st;
    rd      = r;
    wr      = w;
    addr    = a;
    data_in = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;

    // Reset with a write presented: it must be ignored.
    applyStimulus(1, 0, 1, 16'h0010, 16'h1234);
    checkOutput("rst_stall", 16'(stall), 16'h0);
    checkOutput("rst_err", 16'(err), 16'h0);
    applyStimulus(1, 0, 1, 16'h0010, 16'h1234);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("post_rst_busy", 16'(busy), 16'h0);
    checkOutput("post_rst_valid", 16'(rd_valid), 16'h0);
    checkOutput("post_rst_data", data_out, 16'h0);

    // Write BEEF, read it back 4 cycles later.
    applyStimulus(0, 0, 1, 16'h0010, 16'hBEEF);
    checkOutput("wr_beef_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("busy_after_wr", 16'(busy), 16'h1);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("busy_last_cycle", 16'(busy), 16'h1);
    applyStimulus(0, 1, 0, 16'h0010, 16'h0000);
    checkOutput("rd_beef_busy", 16'(busy), 16'h0);
    checkOutput("rd_beef_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("rd_beef_early", 16'(rd_valid), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("rd_beef_valid", 16'(rd_valid), 16'h1);
    checkOutput("rd_beef_data", data_out, 16'hBEEF);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("rd_beef_pulse", 16'(rd_valid), 16'h0);
    checkOutput("rd_beef_idle_data", data_out, 16'h0);

    // Fill banks; bank 0 is rewritten exactly BANK_BUSY cycles after its first write.
    applyStimulus(0, 0, 1, 16'h0008, 16'h5555);
    checkOutput("wr_0008_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 1, 16'h0002, 16'h2222);
    checkOutput("wr_0002_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 1, 16'h0004, 16'h3333);
    applyStimulus(0, 0, 1, 16'h0006, 16'h4444);
    applyStimulus(0, 0, 1, 16'h0000, 16'h1111);
    checkOutput("wr_0000_reaccept", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);

    // Back-to-back reads across the four banks.
    applyStimulus(0, 1, 0, 16'h0000, 16'h0000);
    checkOutput("pipe_r0_stall", 16'(stall), 16'h0);
    applyStimulus(0, 1, 0, 16'h0002, 16'h0000);
    checkOutput("pipe_r1_stall", 16'(stall), 16'h0);
    applyStimulus(0, 1, 0, 16'h0004, 16'h0000);
    checkOutput("pipe_r2_stall", 16'(stall), 16'h0);
    checkOutput("pipe_ret0_valid", 16'(rd_valid), 16'h1);
    checkOutput("pipe_ret0_data", data_out, 16'h1111);
    applyStimulus(0, 1, 0, 16'h0006, 16'h0000);
    checkOutput("pipe_r3_stall", 16'(stall), 16'h0);
    checkOutput("pipe_ret1_data", data_out, 16'h2222);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("pipe_ret2_valid", 16'(rd_valid), 16'h1);
    checkOutput("pipe_ret2_data", data_out, 16'h3333);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("pipe_ret3_valid", 16'(rd_valid), 16'h1);
    checkOutput("pipe_ret3_data", data_out, 16'h4444);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("pipe_done", 16'(rd_valid), 16'h0);

    // Same-bank conflict: three stalled cycles, accepted on the fourth.
    applyStimulus(0, 1, 0, 16'h0000, 16'h0000);
    checkOutput("conf_first_stall", 16'(stall), 16'h0);
    applyStimulus(0, 1, 0, 16'h0008, 16'h0000);
    checkOutput("conf_stall1", 16'(stall), 16'h1);
    checkOutput("conf_busy", 16'(busy), 16'h1);
    applyStimulus(0, 1, 0, 16'h0008, 16'h0000);
    checkOutput("conf_stall2", 16'(stall), 16'h1);
    checkOutput("conf_ret_first", data_out, 16'h1111);
    applyStimulus(0, 1, 0, 16'h0008, 16'h0000);
    checkOutput("conf_stall3", 16'(stall), 16'h1);
    checkOutput("conf_no_extra", 16'(rd_valid), 16'h0);
    applyStimulus(0, 1, 0, 16'h0008, 16'h0000);
    checkOutput("conf_accept", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("conf_gap", 16'(rd_valid), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("conf_ret_valid", 16'(rd_valid), 16'h1);
    checkOutput("conf_ret_data", data_out, 16'h5555);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);

    // Simultaneous rd and wr is illegal and touches nothing.
    applyStimulus(0, 1, 1, 16'h0002, 16'hDEAD);
    checkOutput("illegal_err", 16'(err), 16'h1);
    checkOutput("illegal_stall", 16'(stall), 16'h0);
    checkOutput("illegal_busy", 16'(busy), 16'h0);
    applyStimulus(0, 1, 0, 16'h0002, 16'h0000);
    checkOutput("illegal_after_err", 16'(err), 16'h0);
    checkOutput("illegal_after_busy", 16'(busy), 16'h0);
    checkOutput("illegal_after_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("illegal_no_valid", 16'(rd_valid), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("illegal_mem_valid", 16'(rd_valid), 16'h1);
    checkOutput("illegal_mem_data", data_out, 16'h2222);

    // Reset right after a read accept drops the in-flight read.
    applyStimulus(0, 1, 0, 16'h0004, 16'h0000);
    checkOutput("flush_rd_stall", 16'(stall), 16'h0);
    applyStimulus(1, 1, 1, 16'h0002, 16'h0000);
    checkOutput("flush_rst_err", 16'(err), 16'h0);
    checkOutput("flush_rst_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("flush_valid", 16'(rd_valid), 16'h0);
    checkOutput("flush_busy", 16'(busy), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("flush_valid2", 16'(rd_valid), 16'h0);
    checkOutput("flush_data2", data_out, 16'h0);

    // Unaligned read: rejected when alignment checking is built in, else aliases 0x0002.
    applyStimulus(0, 1, 0, 16'h0003, 16'h0000);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("unaligned_err", 16'(err), 16'h1);
`else
    checkOutput("unaligned_err", 16'(err), 16'h0);
`endif
    checkOutput("unaligned_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("unaligned_valid", 16'(rd_valid), 16'h0);
    checkOutput("unaligned_data", data_out, 16'h0);
`else
    checkOutput("unaligned_valid", 16'(rd_valid), 16'h1);
    checkOutput("unaligned_data", data_out, 16'h2222);
`endif

    // Memory contents survive reset.
    applyStimulus(0, 1, 0, 16'h0004, 16'h0000);
    checkOutput("keep_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("keep_valid", 16'(rd_valid), 16'h1);
    checkOutput("keep_data", data_out, 16'h3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_bank_ctrl.md
MEM_BANK_CTRL -- requirements
Module: mem_bank_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  16  byte address; bank = addr[2:1], row = addr[15:3].
- data_in  in  16  write data.
- wr  in  1  write request.
- rd  in  1  read request.
- data_out  out  16  read data.
- rd_valid  out  1  data_out holds valid read data this cycle.
- stall  out  1  request not accepted this cycle; requester holds it.
- busy  out  4  per-bank busy flags.
- err  out  1  illegal request this cycle.

REQ-002 SHALL have parameters, one per line: name, default, meaning.
- BANK_BUSY, 4, cycles a bank stays occupied per access, counting the accept cycle.
- RD_LAT, 2, cycles from read accept to rd_valid.

Function
REQ-003 SHALL accept a request when (rd ^ wr) is 1, busy[bank] is 0, and err is 0; acceptance is combinational in the same cycle.
REQ-004 SHALL drive stall = (rd | wr) & busy[bank] & ~err.
REQ-005 SHALL load a bank's down-counter with BANK_BUSY-1 on accept and decrement it each cycle to 0.
- busy[b] = (counter != 0).
- A bank is therefore re-acceptable exactly BANK_BUSY cycles after its previous accept.
REQ-006 SHALL write data_in to bank[addr[2:1]][addr[15:3]] at the clock edge ending the accept cycle.
REQ-007 SHALL, for an accepted read in cycle N:
- assert rd_valid for exactly one cycle at N+RD_LAT;
- present the stored word on data_out in that cycle;
- drive data_out = 16'h0000 in all other cycles.
REQ-008 SHALL keep the read path fully pipelined: accepted reads to different banks in consecutive cycles return in consecutive cycles, in accept order.
REQ-009 SHALL, on a read and write to the same row accepted in the same bank, return the newly written data (write-before-read ordering through the bank).
REQ-010 SHALL, when rd & wr are both 1:
- assert err;
- perform no access;
- hold busy unchanged;
- drive stall 0.
REQ-011 SHALL treat a stalled request as not having occurred; no state changes.
REQ-012 SHALL, when rd = wr = 0, leave all outputs at idle values except busy countdown and in-flight read returns.

Reset
REQ-013 SHALL, in a cycle with rst = 1:
- clear all bank counters, giving busy = 4'b0000;
- drop all in-flight reads, giving rd_valid 0 and data_out 0 on the following cycle;
- drive stall 0 and err 0.
REQ-014 SHALL ignore requests presented during reset.
REQ-015 SHALL leave memory contents unchanged by reset.

Configuration
REQ-016 SHALL support macro MEM_ALIGN_CHECK_EN.
- Defined: a request with addr[0] = 1 asserts err that cycle; the request is not accepted, with no state change and stall 0.
- Undefined: addr[0] is ignored and unaligned requests proceed as aligned.

Structure
REQ-017 SHALL place the following in shared package mem_pkg:
- BANK_BUSY and RD_LAT defaults;
- bank-index width (2) and row width (13);
- bank-select slice positions.
REQ-018 SHALL instantiate sub-module mem_bank four times. Each instance holds:
- an 8K x 16 storage array;
- its busy down-counter;
- its RD_LAT-deep read pipeline.
The top level decodes the bank, generates stall and err, and ORs the four read returns.
REQ-019 SHALL build all state elements from the team's dff cell or equivalent synchronous-reset flops; storage arrays are excepted.

Verification
REQ-020 The bench SHALL cover the following scenarios.
- Write 16'hBEEF to addr 16'h0010, then read 16'h0010 after 4 cycles: stall 0 both times; rd_valid and data_out = 16'hBEEF exactly 2 cycles after the read accept.
- Reads to 16'h0000, 0002, 0004, 0006 in consecutive cycles: no stall; four rd_valid pulses in consecutive cycles, in order.
- Read 16'h0000, then 16'h0008 (same bank 0) next cycle: stall high for 3 cycles; accepted on the 4th cycle after the first accept.
- rd = wr = 1 at 16'h0002: err high one cycle, stall 0, busy unchanged, no rd_valid; memory word unchanged on a later read.
- Read accepted, then rst pulsed the next cycle: no rd_valid appears; busy = 0 after reset.
- With MEM_ALIGN_CHECK_EN defined, read 16'h0003: err 1 and no access. Undefined: returns the word stored at 16'h0002.
